// File: rtl/cc_pkg.sv
// Shared constants and types for the cache-fill read path: AXI encodings,
// line geometry and the responder FSM state type.
package cc_pkg;
  localparam int BEATS_PER_LINE = 8;
  localparam int WORD_W         = 64;
  localparam int LINE_W         = BEATS_PER_LINE * WORD_W;
  localparam int PTR_W          = $clog2(BEATS_PER_LINE);

  localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;
  localparam logic [2:0] AXI_SIZE_8B     = 3'b011;
  localparam logic [3:0] AXI_LEN_LINE    = 4'(BEATS_PER_LINE - 1);
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_FETCH, ST_BURST} resp_state_t;

  typedef struct packed {
    logic [PTR_W-1:0] start;
    logic [3:0]       len;
    logic             err;
  } ar_req_t;

  // Anything other than a full-line 8-byte WRAP burst is answered with SLVERR.
  function automatic logic ar_illegal(logic [3:0] len, logic [2:0] size, logic [1:0] burst);
    return (len != AXI_LEN_LINE) || (size != AXI_SIZE_8B) || (burst != AXI_BURST_WRAP);
  endfunction
endpackage

// File: rtl/mem_read_responder_if.sv
// AXI AR + R channel bundle between the cache fill path (master) and the
// memory-side read responder (slave).
interface mem_read_responder_if
  import cc_pkg::*;
#(parameter int ID_W = 4) ();
  logic [ID_W-1:0]   arid_i;
  logic [31:0]       araddr_i;
  logic [3:0]        arlen_i;
  logic [2:0]        arsize_i;
  logic [1:0]        arburst_i;
  logic              arvalid_i;
  logic              arready_o;
  logic [ID_W-1:0]   rid_o;
  logic [WORD_W-1:0] rdata_o;
  logic [1:0]        rresp_o;
  logic              rlast_o;
  logic              rvalid_o;
  logic              rready_i;

  modport master (
    output arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
    input  arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
  modport slave (
    input  arid_i, araddr_i, arlen_i, arsize_i, arburst_i, arvalid_i, rready_i,
    output arready_o, rid_o, rdata_o, rresp_o, rlast_o, rvalid_o
  );
endinterface

// File: rtl/mem_line_serializer.sv
// Holds one cache line and walks it out word by word from a start word,
// wrapping at the line boundary; flags the final beat of the burst.
module mem_line_serializer
  import cc_pkg::*;
(
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   load,
  input  logic [BEATS_PER_LINE-1:0][WORD_W-1:0]  line,
  input  logic [PTR_W-1:0]                       start,
  input  logic [3:0]                             len,
  input  logic                                   advance,
  output logic [WORD_W-1:0]                      word,
  output logic                                   last
);
  logic [BEATS_PER_LINE-1:0][WORD_W-1:0] line_q;
  logic [PTR_W-1:0]                      ptr_q;
  logic [3:0]                            cnt_q;
  logic [3:0]                            len_q;

  // ptr wraps naturally at 3 bits; cnt tracks beats so bursts longer than
  // a line (error case) still terminate on len.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q <= '0;
      ptr_q  <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
    end else if (load) begin
      line_q <= line;
      ptr_q  <= start;
      cnt_q  <= '0;
      len_q  <= len;
    end else if (advance) begin
      ptr_q  <= ptr_q + PTR_W'(1);
      cnt_q  <= cnt_q + 4'd1;
    end
  end

  assign word = line_q[ptr_q];
  assign last = (cnt_q == len_q);
endmodule

// File: rtl/mem_read_responder.sv
// Memory-side AXI read responder: accepts one AR, waits LATENCY cycles,
// fetches the line and returns it as a critical-word-first WRAP burst.
module mem_read_responder
  import cc_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int ID_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  mem_read_responder_if.slave axi,
  output logic              line_req_o,
  output logic [25:0]       line_addr_o,
  input  logic [LINE_W-1:0] line_rdata_i,
  input  logic              line_rvalid_i
);
  localparam int LAT_W = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

  resp_state_t       state_q, state_d;
  ar_req_t           req_q;
  logic [ID_W-1:0]   id_q;
  logic [LAT_W-1:0]  lat_q;
  logic              ar_hs, ar_err, r_hs, line_hs, lat_done;
  logic              ld, adv, last;
  logic [WORD_W-1:0] word;
  logic              unused_addr;

  assign unused_addr = ^axi.araddr_i[2:0];

  assign ar_err   = ar_illegal(axi.arlen_i, axi.arsize_i, axi.arburst_i);
  assign ar_hs    = (state_q == ST_IDLE) && axi.arvalid_i;
  assign r_hs     = axi.rvalid_o && axi.rready_i;
  // Data can only be legal from the cycle after the request pulse.
  assign line_hs  = (state_q == ST_FETCH) && line_rvalid_i && !line_req_o;
  assign lat_done = (lat_q <= LAT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (ar_hs) state_d = (LATENCY == 0 && !ar_err) ? ST_FETCH : ST_WAIT;
      ST_WAIT:  if (lat_done) state_d = req_q.err ? ST_BURST : ST_FETCH;
      ST_FETCH: if (line_hs) state_d = ST_BURST;
      ST_BURST: if (r_hs && last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      id_q        <= '0;
      lat_q       <= '0;
      line_req_o  <= 1'b0;
      line_addr_o <= '0;
    end else begin
      state_q    <= state_d;
      line_req_o <= (state_d == ST_FETCH) && (state_q != ST_FETCH);
      if (ar_hs) begin
        req_q       <= '{start: axi.araddr_i[5:3], len: axi.arlen_i, err: ar_err};
        id_q        <= axi.arid_i;
        lat_q       <= LAT_W'(LATENCY);
        line_addr_o <= axi.araddr_i[31:6];
      end else if (state_q == ST_WAIT && !lat_done) begin
        lat_q <= lat_q - LAT_W'(1);
      end
    end
  end

  // Error bursts skip the fetch and load an all-zero line instead.
  assign ld  = ((state_q == ST_WAIT) && lat_done && req_q.err) || line_hs;
  assign adv = (state_q == ST_BURST) && r_hs && !last;

  mem_line_serializer u_ser (
    .clk     (clk),
    .rst     (rst),
    .load    (ld),
    .line    (req_q.err ? '0 : line_rdata_i),
    .start   (req_q.start),
    .len     (req_q.len),
    .advance (adv),
    .word    (word),
    .last    (last)
  );

  assign axi.arready_o = (state_q == ST_IDLE);
  assign axi.rvalid_o  = (state_q == ST_BURST);
  assign axi.rlast_o   = axi.rvalid_o && last;
  assign axi.rdata_o   = word;
  assign axi.rid_o     = id_q;
  assign axi.rresp_o   = req_q.err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
endmodule
